cdc_handshake_rx: RTL and testbench

Receiving end of a toggle-based request/acknowledge clock-domain crossing for multi-bit data. A sender in a foreign clock domain holds `from_data` stable, toggles `from_req`, and waits for `to_ack` to toggle back. This block synchronizes the request into its own domain and captures the bus once. It presents the bus downstream with a valid/ready handshake and returns the acknowledge toggle. It is used wherever a bus must cross domains losslessly, one transfer at a time.

---
 rtl/cdc_pkg.sv | 18 +
 rtl/cdc_bit_sync.sv | 25 ++
 rtl/cdc_handshake_rx.sv | 113 +++++++++++
 tb/tb_cdc_handshake_rx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle-handshake clock-domain crossing blocks.
package cdc_pkg;

    // Receiver state: IDLE waits for a new request level, HOLD presents a word.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cdc_rx_state_t;

    // Depth of the request synchronizer chain (meta flop + sync flop).
    localparam int unsigned CDC_SYNC_STAGES = 2;

    // True when a synchronized toggle level differs from the last handled level.
    function automatic logic toggle_pending(input logic sync_level, input logic seen_level);
        return sync_level ^ seen_level;
    endfunction

endpackage

// File: rtl/cdc_bit_sync.sv
// Single-bit two-flop synchronizer with synchronous active-high reset.
module cdc_bit_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    // First flop may go metastable; second flop gives it a full cycle to resolve.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/cdc_handshake_rx.sv
// Receiving side of a toggle request/acknowledge crossing for a multi-bit word.
//
// Handshake (downstream side): a word is presented while out_valid is high and
// out_data is held constant; it is consumed on a rising edge where
// out_valid && out_ready. out_valid may rise regardless of out_ready.
// Handshake (sender side): each change of from_req level is one request; each
// change of to_ack level acknowledges exactly one accepted word.
module cdc_handshake_rx
    import cdc_pkg::*;
#(
    parameter int num_bits = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                from_req,
    input  logic [num_bits-1:0] from_data,
    output logic                to_ack,
    output logic [num_bits-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                protocol_error,
    output cdc_rx_state_t       o_dbg_state,
    output logic                o_dbg_req_sync
);

    logic                w_req_sync;
    logic                w_pending;

    cdc_rx_state_t       r_state;
    cdc_rx_state_t       w_state_nxt;
    logic                r_req_seen;
    logic                w_req_seen_nxt;
    logic                r_ack;
    logic                w_ack_nxt;
    logic [num_bits-1:0] r_data;
    logic [num_bits-1:0] w_data_nxt;
    logic                r_valid;
    logic                w_valid_nxt;
    logic                r_err;
    logic                w_err_nxt;

    cdc_bit_sync u_req_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_async (from_req),
        .o_sync  (w_req_sync)
    );

    assign w_pending = toggle_pending(w_req_sync, r_req_seen);

    // Next-state logic: capture in IDLE, wait for acceptance in HOLD.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_seen_nxt = r_req_seen;
        w_ack_nxt      = r_ack;
        w_data_nxt     = r_data;
        w_valid_nxt    = r_valid;
        w_err_nxt      = r_err;
        case (r_state)
            IDLE: begin
                // The bus has been stable for at least two cycles by now.
                if (w_pending) begin
                    w_data_nxt     = from_data;
                    w_valid_nxt    = 1'b1;
                    w_req_seen_nxt = w_req_sync;
                    w_state_nxt    = HOLD;
                end
            end
            HOLD: begin
                if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                    w_ack_nxt   = ~r_ack;
                    w_state_nxt = IDLE;
                end
                // Sender re-toggled before its ack: flag it, keep the request
                // pending (req_seen untouched) so IDLE services it next.
                if (w_pending) begin
                    w_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, data word and handshake flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req_seen <= w_req_seen_nxt;
            r_ack      <= w_ack_nxt;
            r_data     <= w_data_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign to_ack         = r_ack;
    assign out_data       = r_data;
    assign out_valid      = r_valid;
    assign protocol_error = r_err;
    assign o_dbg_state    = r_state;
    assign o_dbg_req_sync = w_req_sync;

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Bench for cdc_handshake_rx: directed vector table plus hand-written sequences.
module tb_cdc_handshake_rx;
    import cdc_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic tx_clk = 1'b0;
    logic reset = 1'b1;
    always #3 clk = ~clk;        // receiving domain
    always #7 tx_clk = ~tx_clk;  // sender domain, 3:7 period ratio

    logic          from_req = 1'b1;
    logic [31:0]   from_data = 32'h1234_5678;
    logic          out_ready = 1'b0;
    logic          to_ack;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          protocol_error;
    cdc_rx_state_t dbg_state;
    logic          dbg_req_sync;

    cdc_handshake_rx #(.num_bits(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .from_req       (from_req),
        .from_data      (from_data),
        .to_ack         (to_ack),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .protocol_error (protocol_error),
        .o_dbg_state    (dbg_state),
        .o_dbg_req_sync (dbg_req_sync)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_acc = 0;
    logic [31:0] exp_q[$];
    logic        exp_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every accepted word must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                check("accept_unexpected", out_data, 32'hxxxx_xxxx);
            end else begin
                check("accept_data", out_data, exp_q.pop_front());
            end
        end
    end

    // Sender-domain view of to_ack.
    logic tx_ack_meta = 1'b0;
    logic tx_ack_sync = 1'b0;
    always @(posedge tx_clk) begin
        tx_ack_meta <= to_ack;
        tx_ack_sync <= tx_ack_meta;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name, input int max, output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < max) begin
            cycle_sample();
            lat++;
        end
        if (out_valid !== 1'b1) check({name, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    typedef struct {
        logic [31:0] data;
        int          bp_cycles;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int lat;
        tick();
        out_ready = (v.bp_cycles == 0);
        from_data = v.data;
        tick();
        from_req = ~from_req;
        exp_q.push_back(v.exp_data);
        wait_valid("vec_valid", 8, lat);
        check("vec_latency", 32'(lat), 32'(v.exp_lat));
        check("vec_data", out_data, v.exp_data);
        check("vec_ack_before", 32'(to_ack), 32'(exp_ack));
        if (v.bp_cycles == 0) begin
            cycle_sample();
            check("vec_valid_1cyc", 32'(out_valid), 32'd0);
        end else begin
            for (int i = 0; i < v.bp_cycles; i++) begin
                cycle_sample();
                check("bp_valid", 32'(out_valid), 32'd1);
                check("bp_data", out_data, v.exp_data);
                check("bp_ack", 32'(to_ack), 32'(exp_ack));
            end
            tick();
            out_ready = 1'b1;
            cycle_sample();
            check("bp_release_valid", 32'(out_valid), 32'd0);
        end
        exp_ack = ~exp_ack;
        check("vec_ack_after", 32'(to_ack), 32'(exp_ack));
    endtask

    // ---------------- sender model for the stream ----------------
    logic stream_done = 1'b0;

    task automatic tx_send(input logic [31:0] val);
        int budget;
        @(posedge tx_clk);
        #1;
        from_data = val;
        exp_q.push_back(val);
        @(posedge tx_clk);
        #1;
        from_req = ~from_req;
        budget = 0;
        while (tx_ack_sync !== from_req && budget < 100) begin
            @(posedge tx_clk);
            budget++;
        end
        if (tx_ack_sync !== from_req) check("stream_ack_timeout", 32'(tx_ack_sync), 32'(from_req));
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[5];

    initial begin
        int lat;
        int acc0;
        int cyc;

        vecs[0] = '{data: 32'hDEAD_BEEF, bp_cycles: 0,  exp_data: 32'hDEAD_BEEF, exp_lat: 3};
        vecs[1] = '{data: 32'hDEAD_BEEF, bp_cycles: 10, exp_data: 32'hDEAD_BEEF, exp_lat: 3};
        vecs[2] = '{data: 32'h0000_0000, bp_cycles: 1,  exp_data: 32'h0000_0000, exp_lat: 3};
        vecs[3] = '{data: 32'hFFFF_FFFF, bp_cycles: 3,  exp_data: 32'hFFFF_FFFF, exp_lat: 3};
        vecs[4] = '{data: 32'hA5A5_5A5A, bp_cycles: 0,  exp_data: 32'hA5A5_5A5A, exp_lat: 3};

        // Reset with from_req held high.
        for (int i = 0; i < 2; i++) begin
            cycle_sample();
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_ack", 32'(to_ack), 32'd0);
            check("rst_data", out_data, 32'd0);
            check("rst_err", 32'(protocol_error), 32'd0);
            check("rst_req_sync", 32'(dbg_req_sync), 32'd0);
            check("rst_state", 32'(dbg_state), 32'(IDLE));
        end
        reset = 1'b0;
        exp_q.push_back(32'h1234_5678);
        lat = 0;
        while (dbg_req_sync !== 1'b1 && lat < 5) begin
            cycle_sample();
            lat++;
        end
        check("post_rst_sync_le2", 32'(lat <= 2 && dbg_req_sync === 1'b1), 32'd1);
        wait_valid("post_rst_valid", 4, lat);
        check("post_rst_data", out_data, 32'h1234_5678);
        tick();
        out_ready = 1'b1;
        cycle_sample();
        check("post_rst_accept", 32'(out_valid), 32'd0);
        exp_ack = 1'b1;
        check("post_rst_ack", 32'(to_ack), 32'd1);

        // Table-driven transfers.
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Protocol violation: second toggle while the first word is held.
        tick();
        out_ready = 1'b0;
        from_data = 32'h1111_1111;
        tick();
        from_req = ~from_req;
        exp_q.push_back(32'h1111_1111);
        wait_valid("pv_valid", 8, lat);
        check("pv_err_before", 32'(protocol_error), 32'd0);
        tick();
        from_data = 32'h2222_2222;
        tick();
        from_req = ~from_req;
        exp_q.push_back(32'h2222_2222);
        repeat (4) cycle_sample();
        check("pv_err_set", 32'(protocol_error), 32'd1);
        check("pv_data_held", out_data, 32'h1111_1111);
        check("pv_state", 32'(dbg_state), 32'(HOLD));
        check("pv_ack_held", 32'(to_ack), 32'(exp_ack));
        tick();
        out_ready = 1'b1;
        cycle_sample();
        exp_ack = ~exp_ack;
        check("pv_accept1_valid", 32'(out_valid), 32'd0);
        check("pv_accept1_ack", 32'(to_ack), 32'(exp_ack));
        cycle_sample();
        check("pv_next_valid", 32'(out_valid), 32'd1);
        check("pv_next_data", out_data, 32'h2222_2222);
        cycle_sample();
        exp_ack = ~exp_ack;
        check("pv_accept2_valid", 32'(out_valid), 32'd0);
        check("pv_accept2_ack", 32'(to_ack), 32'(exp_ack));
        check("pv_err_sticky", 32'(protocol_error), 32'd1);

        // Mid-transfer reset (sender reset in the same window).
        tick();
        out_ready = 1'b0;
        from_data = 32'h3333_3333;
        tick();
        from_req = ~from_req;
        wait_valid("mr_valid", 8, lat);
        check("mr_state_hold", 32'(dbg_state), 32'(HOLD));
        tick();
        reset = 1'b1;
        from_req = 1'b0;
        cycle_sample();
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_ack", 32'(to_ack), 32'd0);
        check("mr_state", 32'(dbg_state), 32'(IDLE));
        check("mr_err_cleared", 32'(protocol_error), 32'd0);
        check("mr_data", out_data, 32'd0);
        tick();
        reset = 1'b0;
        exp_ack = 1'b0;
        repeat (5) cycle_sample();
        check("mr_quiet", 32'(out_valid), 32'd0);

        // Stream of 8 words from a sender in the other clock domain.
        acc0 = n_acc;
        cyc = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) tx_send(32'(i));
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    tick();
                    out_ready = (cyc % 3) != 0;
                    cyc++;
                end
            end
        join
        repeat (4) cycle_sample();
        check("stream_count", 32'(n_acc - acc0), 32'd8);
        check("stream_queue_empty", 32'(exp_q.size()), 32'd0);
        check("stream_err", 32'(protocol_error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
